signed_div_clb: RTL



---
 rtl/signed_div_clb_if.sv | 24 ++
 rtl/signed_div_clb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/signed_div_clb_if.sv
// Handshake and operand/result bundle for the signed Q3.12 CLB divider.
// The master drives start/a/b; the divider (slave) returns busy/done/q and flags.
interface signed_div_clb_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic             overflow;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, overflow, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, overflow, div_zero
  );
endinterface

// File: rtl/signed_div_clb.sv
// Iterative restoring signed fixed-point divider, q = a / b, one quotient bit per cycle.
// Optional macro SIGNED_DIV_ROUND_EN: round half away from zero instead of truncating.
module signed_div_clb #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  signed_div_clb_if.slave bus
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N);
  localparam logic [N:0]       POS_MAX = (N+1)'((1 << (WIDTH-1)) - 1);
  localparam logic [N:0]       NEG_MAX = (N+1)'(1 << (WIDTH-1));
  localparam logic [WIDTH-1:0] Q_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q;
  logic             sign_q, a_neg_q, zero_q;
  logic [WIDTH-1:0] mb_q;
  logic [N-1:0]     dvd_q;
  logic [WIDTH:0]   rem_q;
  logic [N-1:0]     quo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, ov_q, dz_q;
  logic [WIDTH-1:0] q_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, rem_d;
  logic             qbit;
  logic [N:0]       mag;
  logic [WIDTH-1:0] q_d;
  logic             ov_d, dz_d;

  // Negating 0x8000 wraps back to 0x8000, which read unsigned is the legal magnitude 32768.
  assign abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], dvd_q[N-1]};
    qbit   = (rem_sh >= {1'b0, mb_q});
    rem_d  = qbit ? (rem_sh - {1'b0, mb_q}) : rem_sh;
  end

  always_comb begin
`ifdef SIGNED_DIV_ROUND_EN
    mag = {1'b0, quo_q} + (N+1)'({rem_q, 1'b0} >= {2'b00, mb_q});
`else
    mag = {1'b0, quo_q};
`endif
    q_d  = '0;
    ov_d = 1'b0;
    dz_d = 1'b0;
    if (zero_q) begin
      dz_d = 1'b1;
      q_d  = a_neg_q ? Q_NEG : Q_POS;
    end else if (!sign_q && (mag > POS_MAX)) begin
      ov_d = 1'b1;
      q_d  = Q_POS;
    end else if (sign_q && (mag > NEG_MAX)) begin
      ov_d = 1'b1;
      q_d  = Q_NEG;
    end else begin
      q_d  = sign_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      mb_q    <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // busy rises one edge after acceptance and stays through the done cycle
      busy_q <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            a_neg_q <= bus.a[WIDTH-1];
            zero_q  <= (bus.b == '0);
            mb_q    <= abs_b;
            dvd_q   <= {abs_a, {FRAC{1'b0}}};
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[N-2:0], qbit};
          dvd_q <= {dvd_q[N-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) state_q <= FIX;
        end
        FIX: begin
          q_q     <= q_d;
          ov_q    <= ov_d;
          dz_q    <= dz_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign bus.overflow = ov_q;
  assign bus.div_zero = dz_q;

endmodule
